// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// parity rule used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Widest payload the parity helper accepts; narrower data is zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int UART_MAX_DATA_WIDTH = 16;

    // par_typ = 0: even (XOR of data), par_typ = 1: odd (XNOR of data)
    function automatic logic uart_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                         input logic par_typ);
        return par_typ ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side and line-side signals of the UART transmitter.
// Handshake: the byte is accepted at a rising edge where DATA_VALID=1 and Busy=0;
// requests while Busy=1 are dropped, so the requester holds DATA_VALID until Busy rises.
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Loadable down-counter timing one bit period; tick is high while the count is zero.
module uart_tx_bit_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tick
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// every bit held for Prescale clocks. Outputs come straight from registers.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_if.slave       bus,
    output uart_tx_state_e state_dbg
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_tx_state_e            state;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [IDX_W-1:0]          bit_idx;
    logic                      tx_out_q;
    logic                      busy_q;

    logic                      tick;
    logic                      accept;
    logic                      timer_load;
    logic [PRESCALE_WIDTH-1:0] prescale_in;
    logic [PRESCALE_WIDTH-1:0] timer_value;

    // A prescale of 0 would stall the timer, so it is run as 1 clock per bit.
    assign prescale_in = (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
    assign accept      = (state == IDLE) && bus.DATA_VALID;
    // The stop bit ends in IDLE, where the timer just rests at zero.
    assign timer_load  = accept || ((state != IDLE) && (state != STOP) && tick);
    assign timer_value = accept ? (prescale_in - PRESCALE_WIDTH'(1))
                                : (prescale_q - PRESCALE_WIDTH'(1));

    uart_tx_bit_timer #(
        .WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
            bit_idx    <= '0;
            tx_out_q   <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.DATA_VALID) begin
                        data_q     <= bus.P_DATA;
                        par_en_q   <= bus.PAR_EN;
                        par_typ_q  <= bus.PAR_TYP;
                        prescale_q <= prescale_in;
                        bit_idx    <= '0;
                        tx_out_q   <= UART_START_BIT;
                        busy_q     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_idx  <= '0;
                        tx_out_q <= data_q[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_IDX) begin
                            if (par_en_q) begin
                                tx_out_q <= uart_parity(UART_MAX_DATA_WIDTH'(data_q), par_typ_q);
                                state    <= PARITY;
                            end else begin
                                tx_out_q <= UART_STOP_BIT;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            tx_out_q <= data_q[bit_idx + 1'b1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_out_q <= UART_STOP_BIT;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        tx_out_q <= UART_IDLE_LEVEL;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_out_q <= UART_IDLE_LEVEL;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.Busy   = busy_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model checked every cycle, plus
// literal frame patterns, busy lengths and frame spacing.
module tb_uart_tx;
    import uart_pkg::*;

    logic clk;
    logic rst;
    uart_tx_state_e state_dbg;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line model ----------------
    logic m_q[$];
    logic m_line;
    logic m_busy;
    logic frm[$];
    int   m_p;
    int   m_ones;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_line = 1'b1;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_q.size() > 0) begin
                m_line = m_q.pop_front();
            end else begin
                m_line = 1'b1;
                m_busy = 1'b0;
            end
        end else if (bus.DATA_VALID) begin
            m_p    = (bus.Prescale == 0) ? 1 : int'(bus.Prescale);
            m_ones = $countones(bus.P_DATA);
            frm.delete();
            frm.push_back(1'b0);
            for (int i = 0; i < 8; i++) frm.push_back(bus.P_DATA[i]);
            if (bus.PAR_EN) frm.push_back(bus.PAR_TYP ? (m_ones % 2 == 0) : (m_ones % 2 == 1));
            frm.push_back(1'b1);
            foreach (frm[k]) for (int c = 0; c < m_p; c++) m_q.push_back(frm[k]);
            m_line = m_q.pop_front();
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        check_bit("tx_out", bus.TX_OUT, m_line);
        check_bit("busy", bus.Busy, m_busy);
    end

    // ---------------- frame recorder ----------------
    logic rec_buf[0:1023];
    logic last_frame[0:1023];
    int   rec_len;
    int   last_len;
    int   frame_count;
    int   cyc;
    int   rise_cyc;
    logic busy_prev;

    initial begin
        rec_len = 0; last_len = 0; frame_count = 0; cyc = 0; rise_cyc = 0; busy_prev = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            rec_len   = 0;
            busy_prev = 1'b0;
        end else begin
            if (bus.Busy) begin
                if (!busy_prev) begin
                    rise_cyc = cyc;
                    rec_len  = 0;
                end
                if (rec_len < 1024) rec_buf[rec_len] = bus.TX_OUT;
                rec_len++;
            end else if (busy_prev) begin
                last_len   = rec_len;
                last_frame = rec_buf;
                frame_count++;
            end
            busy_prev = bus.Busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_frame(input int prev, input string name);
        int t;
        t = 0;
        while (frame_count <= prev && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (frame_count <= prev) begin
            errors++;
            $display("FAIL %s: no completed frame, count %0d expected above %0d", name, frame_count, prev);
        end
    endtask

    task automatic wait_busy(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.Busy && t < 200);
        checks++;
        if (!bus.Busy) begin
            errors++;
            $display("FAIL %s: Busy never rose, got %b expected 1", name, bus.Busy);
        end
    endtask

    task automatic send(input logic [7:0] data, input logic pen, input logic ptyp,
                        input logic [5:0] pre, input string name);
        @(negedge clk);
        bus.P_DATA     = data;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Prescale   = pre;
        bus.DATA_VALID = 1'b1;
        wait_busy(name);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [10:0] exp_bits,
                               input int n, input int p);
        check_int({name, "_len"}, last_len, n * p);
        for (int k = 0; k < n; k++)
            check_bit($sformatf("%s_bit%0d", name, k), last_frame[k * p + p / 2], exp_bits[k]);
    endtask

    // ---------------- directed stimulus ----------------
    int fc;
    int rise1;

    initial begin
        rst            = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd1;
        checks         = 0;
        errors         = 0;

        // Reset held with a pending request: line stays idle.
        @(negedge clk);
        bus.P_DATA     = 8'h45;
        bus.DATA_VALID = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_bit("rst_tx", bus.TX_OUT, 1'b1);
            check_bit("rst_busy", bus.Busy, 1'b0);
        end
        check_int("rst_state", int'(state_dbg), int'(IDLE));
        fc  = frame_count;
        rst = 1'b1;
        @(negedge clk);
        check_bit("first_accept_busy", bus.Busy, 1'b1);
        check_bit("first_accept_start", bus.TX_OUT, 1'b0);
        bus.DATA_VALID = 1'b0;
        wait_frame(fc, "after_reset");
        check_frame("f45_p1", 11'b01010001010, 10, 1);

        // No parity, Prescale 8.
        fc = frame_count;
        send(8'h45, 1'b0, 1'b0, 6'd8, "f45");
        wait_frame(fc, "f45");
        check_frame("f45_p8", 11'b01010001010, 10, 8);

        // Parity frames at Prescale 4.
        fc = frame_count;
        send(8'hFF, 1'b1, 1'b0, 6'd4, "fff_even");
        wait_frame(fc, "fff_even");
        check_frame("fff_even", 11'b10111111110, 11, 4);

        fc = frame_count;
        send(8'hA8, 1'b1, 1'b1, 6'd4, "fa8_odd");
        wait_frame(fc, "fa8_odd");
        check_frame("fa8_odd", 11'b10101010000, 11, 4);

        fc = frame_count;
        send(8'hA9, 1'b1, 1'b1, 6'd4, "fa9_odd");
        wait_frame(fc, "fa9_odd");
        check_frame("fa9_odd", 11'b11101010010, 11, 4);

        // Request and control changes mid-frame are ignored.
        fc = frame_count;
        send(8'h45, 1'b0, 1'b0, 6'd8, "busy_prot");
        repeat (30) @(negedge clk);
        bus.P_DATA     = 8'h33;
        bus.Prescale   = 6'd2;
        bus.PAR_EN     = 1'b1;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        wait_frame(fc, "busy_prot");
        check_frame("busy_prot", 11'b01010001010, 10, 8);
        repeat (40) @(negedge clk);
        check_int("dropped_req", frame_count, fc + 1);
        check_bit("dropped_idle", bus.Busy, 1'b0);

        // Back-to-back with DATA_VALID held, Prescale 0 runs as 1.
        fc = frame_count;
        @(negedge clk);
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd0;
        bus.DATA_VALID = 1'b1;
        wait_busy("b2b_first");
        bus.P_DATA = 8'hFF;
        wait_frame(fc, "b2b_first");
        check_frame("b2b_00", 11'b01000000000, 10, 1);
        rise1 = rise_cyc;
        wait_busy("b2b_second");
        bus.DATA_VALID = 1'b0;
        wait_frame(fc + 1, "b2b_second");
        check_frame("b2b_ff", 11'b01111111110, 10, 1);
        check_int("b2b_spacing", rise_cyc - rise1, 11);

        // Asynchronous reset mid-frame returns the line high at once.
        fc = frame_count;
        send(8'h45, 1'b0, 1'b0, 6'd8, "mid_rst");
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_bit("mid_rst_tx", bus.TX_OUT, 1'b1);
        check_bit("mid_rst_busy", bus.Busy, 1'b0);
        check_int("mid_rst_state", int'(state_dbg), int'(IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_int("mid_rst_no_frame", frame_count, fc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
